// File: rtl/rc4_pkg.sv
// Shared types for the RC4 keystream consumer: byte type, unpacker state and index width.
package rc4_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic {
        KS_EMPTY = 1'b0,
        KS_HOLD  = 1'b1
    } ks_state_t;

    localparam int NUMS_OF_BYTES_DFLT = 4;

    // Byte-index width; a single-byte word still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W = idx_width(NUMS_OF_BYTES_DFLT);

endpackage

// File: rtl/rc4_stream_xor_if.sv
// Keystream, data-in and data-out streams plus flush/status for rc4_stream_xor.
interface rc4_stream_xor_if #(
    parameter int NUMS_OF_BYTES = 4,
    parameter int CNT_W         = 16
);
    import rc4_pkg::*;

    logic                       ks_valid;
    logic                       ks_ready;
    logic [NUMS_OF_BYTES*8-1:0] ks_data;
    logic                       in_valid;
    logic                       in_ready;
    byte_t                      in_data;
    logic                       in_last;
    logic                       out_valid;
    logic                       out_ready;
    byte_t                      out_data;
    logic                       out_last;
    logic                       flush;
    logic [CNT_W-1:0]           byte_count;
    logic                       busy;

    modport master (
        output ks_valid, ks_data, in_valid, in_data, in_last, out_ready, flush,
        input  ks_ready, in_ready, out_valid, out_data, out_last, byte_count, busy
    );

    modport slave (
        input  ks_valid, ks_data, in_valid, in_data, in_last, out_ready, flush,
        output ks_ready, in_ready, out_valid, out_data, out_last, byte_count, busy
    );

endinterface

// File: rtl/rc4_ks_unpacker.sv
// Holds one packed keystream word and presents it a byte at a time, byte 0 first.
// A take on the last byte, or a take flagged last, retires the word; a new word may load in that same cycle.
module rc4_ks_unpacker
    import rc4_pkg::*;
#(
    parameter int NUMS_OF_BYTES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_ks_valid,
    output logic                       o_ks_ready,
    input  logic [NUMS_OF_BYTES*8-1:0] i_ks_data,
    output byte_t                      o_byte,
    output logic                       o_byte_vld,
    input  logic                       i_take,
    input  logic                       i_last
);

    localparam int                 L_IDX_W   = idx_width(NUMS_OF_BYTES);
    localparam logic [L_IDX_W-1:0] L_IDX_MAX = L_IDX_W'(NUMS_OF_BYTES - 1);

    ks_state_t                  r_state;
    ks_state_t                  w_state_nxt;
    logic [NUMS_OF_BYTES*8-1:0] r_word;
    logic [L_IDX_W-1:0]         r_idx;
    logic                       w_eow;
    logic                       w_load;

    // A message end also retires the word so the next message starts on fresh keystream.
    assign w_eow      = i_take && (i_last || (r_idx == L_IDX_MAX));
    assign o_ks_ready = !i_flush && ((r_state == KS_EMPTY) || w_eow);
    assign w_load     = i_ks_valid && o_ks_ready;
    assign o_byte_vld = (r_state == KS_HOLD);
    assign o_byte     = byte_t'(r_word >> {r_idx, 3'b000});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= KS_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            KS_EMPTY: if (w_load) w_state_nxt = KS_HOLD;
            KS_HOLD:  if (w_eow)  w_state_nxt = w_load ? KS_HOLD : KS_EMPTY;
            default:              w_state_nxt = KS_EMPTY;
        endcase
        if (i_flush) begin
            w_state_nxt = KS_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word <= '0;
            r_idx  <= '0;
        end else begin
            if (w_load) begin
                r_word <= i_ks_data;
            end
            if (i_flush || w_load || w_eow) begin
                r_idx <= '0;
            end else if (i_take) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rc4_stream_xor.sv
// XORs a byte stream with unpacked RC4 keystream (encrypt == decrypt); one registered output byte.
// Latency 1 cycle, 1 byte/cycle sustained; input stalls while the output register is full and not drained.
module rc4_stream_xor
    import rc4_pkg::*;
#(
    parameter int NUMS_OF_BYTES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    rc4_stream_xor_if.slave  bus
);

    byte_t            w_ks_byte;
    logic             w_ks_byte_vld;
    logic             w_out_free;
    logic             w_consume;
    logic             r_out_valid;
    byte_t            r_out_data;
    logic             r_out_last;
    logic [CNT_W-1:0] r_byte_count;

    assign w_out_free  = !r_out_valid || bus.out_ready;
    assign bus.in_ready = w_ks_byte_vld && w_out_free && !bus.flush;
    assign w_consume   = bus.in_valid && bus.in_ready;

    rc4_ks_unpacker #(
        .NUMS_OF_BYTES (NUMS_OF_BYTES)
    ) u_unpacker (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (bus.flush),
        .i_ks_valid (bus.ks_valid),
        .o_ks_ready (bus.ks_ready),
        .i_ks_data  (bus.ks_data),
        .o_byte     (w_ks_byte),
        .o_byte_vld (w_ks_byte_vld),
        .i_take     (w_consume),
        .i_last     (bus.in_last)
    );

    // Flush drops a pending output byte; data/last only change on a consume, so they stay stable under stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_byte_count <= '0;
        end else if (bus.flush) begin
            r_out_valid  <= 1'b0;
            r_byte_count <= '0;
        end else if (w_consume) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= bus.in_data ^ w_ks_byte;
            r_out_last   <= bus.in_last;
            r_byte_count <= r_byte_count + 1'b1;
        end else if (bus.out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.out_last   = r_out_last;
    assign bus.byte_count = r_byte_count;
    assign bus.busy       = w_ks_byte_vld || r_out_valid;

endmodule

// File: doc/rc4_stream_xor.md
# rc4_stream_xor

Consumer side of the RC4 keystream generator. Accepts packed keystream words (NUMS_OF_BYTES bytes per word, the same packing the generator emits on its keystream bus), unpacks them byte by byte and XORs each byte with an incoming data byte stream. Because RC4 is symmetric, the block performs both encryption and decryption. It sits between the keystream generator and the byte-stream datapath, with valid/ready handshakes on all three streams.

## Interface
- NUMS_OF_BYTES, 4, keystream bytes per packed word (1..16)
- CNT_W, 16, width of the processed-byte counter
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- ks_valid  in  1  keystream word valid
- ks_ready  out  1  block accepts keystream word
- ks_data  in  NUMS_OF_BYTES*8  packed keystream; byte 0 = [7:0] is used first
- in_valid  in  1  data byte valid
- in_ready  out  1  block accepts data byte
- in_data  in  8  plaintext or ciphertext byte
- in_last  in  1  last byte of message
- out_valid  out  1  result byte valid
- out_ready  in  1  downstream accepts result
- out_data  out  8  in_data XOR keystream byte
- out_last  out  1  in_last, delayed with its byte
- flush  in  1  synchronous discard of all held state
- byte_count  out  CNT_W  bytes emitted since reset or flush
- busy  out  1  keystream word held, or out_valid high

## Operation
- States: KS_EMPTY (no word held) and KS_HOLD (word held, byte index idx in 0..NUMS_OF_BYTES-1).
- KS_EMPTY: ks_ready=1. On ks_valid, load ks_data, set idx=0, go to KS_HOLD.
- out_free = !out_valid || out_ready.
- consume = in_valid && in_ready.
- in_ready = (state==KS_HOLD) && out_free && !flush.
- On consume: out_data <= in_data ^ word[idx*8 +: 8], out_last <= in_last, out_valid <= 1, byte_count += 1 (wraps to 0 at 2^CNT_W).
- End of word: a consume with idx==NUMS_OF_BYTES-1, or a consume with in_last=1. Either one discards the remaining bytes of the word and ends the word. A new message therefore always starts on a fresh word.
- ks_ready = !flush && (state==KS_EMPTY || (consume && end of word)). A word accepted in the same cycle as the end-of-word consume reloads directly into KS_HOLD with idx=0. This gives zero bubbles.
- Otherwise, a consume increments idx.
- Output register: out_valid clears when out_ready is high and no new consume occurs. out_data and out_last hold stable while out_valid && !out_ready.
- flush (highest priority) forces in_ready=0, ks_ready=0 and out_valid=0 that cycle, and clears byte_count and idx. The next state is KS_EMPTY. Any output byte pending at that point is dropped.

## Timing
- Reset values: state KS_EMPTY, ks_ready=1 (combinational), in_ready=0, out_valid=0, out_data=0, out_last=0, byte_count=0, busy=0.
- Latency: a byte accepted at edge N has out_valid high after edge N; 1 cycle.
- Sustained throughput: 1 byte/cycle while keystream and downstream keep up.
- First keystream word after empty: in_ready rises the cycle after the ks handshake.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). The held word is lost and the generator must be re-keyed.
- No combinational path from out_ready to out_data. ks_ready and in_ready depend combinationally on in_valid, out_ready and flush.

## Structure
- The shared package rc4_pkg holds:
  - byte_t (logic [7:0])
  - the ks_state_t enum {KS_EMPTY, KS_HOLD}
  - localparam IDX_W = $clog2(NUMS_OF_BYTES) (minimum 1)
- One sub-module, rc4_ks_unpacker: word register, idx counter and the KS_EMPTY/KS_HOLD FSM. It presents one keystream byte with a byte-valid signal and a take/last input.
- The top level holds the XOR, the output register, byte_count and busy.

## Test plan
- Single word: ks_data=32'h44332211; in bytes 00,01,02,03 with out_ready=1 -> out 11,23,31,47 on consecutive cycles; ks_ready=1 in the cycle byte 03 is consumed; byte_count=4.
- Backpressure: the same word, out_ready low for 3 cycles after the first output -> out_data=11 held for 3 cycles, in_ready=0, no byte lost or duplicated.
- Early in_last: word 32'h44332211, bytes 00,01 with in_last on 01 -> out 11,23 with out_last=1. Next word 32'hDDCCBBAA, byte FF -> out 55 (bytes 33/44 discarded).
- Known vector: keystream EB 9F 77 81 B7 34 CA 72 A7 (key "Key"), input "Plaintext" -> BB F3 16 E8 D9 40 AF 0A D3. Feeding that output back through with the same keystream returns "Plaintext".
- Flush mid-word: after 2 of 4 bytes, with out_valid high and out_ready=0, assert flush for 1 cycle -> out_valid=0, byte_count=0, ks_ready=1 next cycle, in_ready=0 until a new word arrives.
- Async reset: assert rst between clock edges while in KS_HOLD -> outputs go to reset values before the next edge. After release, first word 32'h44332211 with byte 00 -> out 11.
